alarm_scheduler: RTL and testbench
==================================

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 SHALL have parameter SNOOZE_MIN, default 5, minutes added to current time on a snooze press (range 1-59).
REQ-002 SHALL have parameter RING_TIMEOUT_SEC, default 60, seconds of ringing before automatic stop.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, maximum snoozes per alarm event (range 1-3).
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk and rst.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tick_1s  input  1  one-cycle pulse per second, coincident with the time-base increment.
REQ-008 cur_hour/cur_min/cur_sec  input  6 each  current binary time (0-23, 0-59, 0-59).
REQ-009 alm_hour/alm_min  input  6 each  programmed binary alarm time.
REQ-010 alarm_en  input  1  level; 0 disables and clears all alarm activity.
REQ-011 btn_stop/btn_snooze  input  1 each  level buttons; rising edges detected internally.
REQ-012 state  output  2  IDLE=00, ARMED=01, RINGING=10, SNOOZE=11.
REQ-013 ringing  output  1  high exactly while state==RINGING.
REQ-014 buzzer  output  1  0.5 Hz drive pattern while ringing, else 0.
REQ-015 snooze_count  output  2  snoozes used in the current alarm event.
REQ-016 eff_hour/eff_min  output  6 each  next time at which ringing starts.

Function
REQ-017 All outputs SHALL be registered; each edge detector SHALL use a previous-value register, reset to 0.
REQ-018 match SHALL be (cur_hour==eff_hour && cur_min==eff_min && cur_sec==0); a trigger SHALL be a rising edge of match (match && !match_prev) only, so at most one trigger per minute.
REQ-019 In IDLE and ARMED, eff_hour/eff_min SHALL load alm_hour/alm_min every cycle; in RINGING/SNOOZE they SHALL hold except as in REQ-024.
REQ-020 IDLE -> ARMED on the cycle after alarm_en=1 is sampled.
REQ-021 Any state -> IDLE on the cycle after alarm_en=0 is sampled: snooze_count=0, ringing=0, buzzer=0, ring counter=0; this has top priority.
REQ-022 ARMED -> RINGING on trigger: buzzer=1, ring counter=0.
REQ-023 RINGING: each tick_1s SHALL increment the ring counter and toggle buzzer.
REQ-024 RINGING + btn_snooze edge with snooze_count<MAX_SNOOZE -> SNOOZE: snooze_count+1, eff = cur time + SNOOZE_MIN with minute wrap mod 60 carrying into hour, and hour wrap mod 24; with snooze_count==MAX_SNOOZE the press SHALL be ignored.
REQ-025 RINGING + btn_stop edge -> ARMED, snooze_count=0, buzzer=0.
REQ-026 RINGING with ring counter==RING_TIMEOUT_SEC-1 and tick_1s -> ARMED exactly as REQ-025.
REQ-027 Simultaneous stop and snooze edges SHALL act as stop; a stop/timeout coincident with tick_1s SHALL leave buzzer 0.
REQ-028 SNOOZE -> RINGING on trigger against eff (REQ-022 actions; snooze_count held).
REQ-029 SNOOZE + btn_stop edge -> ARMED, snooze_count=0.
REQ-030 Buttons held continuously SHALL produce no further actions after the first edge.
REQ-031 Since match is still true after stop, the alarm SHALL NOT retrigger in the same minute.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, ringing=0, buzzer=0, snooze_count=0, eff_hour=eff_min=0, ring counter=0 and edge registers=0, regardless of clk.
REQ-033 After rst deasserts, operation SHALL resume at the first rising clk edge via REQ-020; a reset mid-ring SHALL not resume ringing within the same minute.

Verification
REQ-034 alm=07:30, alarm_en=1, time advances 07:29:59 -> 07:30:00 -> state=RINGING, ringing=1, buzzer=1, toggling every tick.
REQ-035 Ringing at 07:30:10, btn_snooze pulse -> state=SNOOZE, snooze_count=1, eff=07:35; at 07:35:00 -> RINGING again.
REQ-036 alm=23:58 ringing, snooze -> eff=00:03; repeat until snooze_count=3, fourth snooze ignored, state stays RINGING.
REQ-037 Ringing with no input for 60 ticks -> state=ARMED, buzzer=0, eff reverts to alm; no retrigger at 07:30:xx.
REQ-038 btn_stop and btn_snooze rising in the same cycle while RINGING -> ARMED, snooze_count=0.
REQ-039 rst pulsed mid-ring (asynchronous, between clk edges) -> outputs at reset values immediately; alarm_en=0 during SNOOZE -> IDLE next cycle.

Source files
------------

// File: rtl/alarm_scheduler.sv
// Alarm sequencer: arms on alarm_en, rings on the minute match, supports bounded snoozes,
// manual stop and automatic ring timeout. Buzzer toggles on every second tick while ringing.
//   state   | meaning
//   IDLE    | alarm disabled, eff tracks alm
//   ARMED   | waiting for eff time, eff tracks alm
//   RINGING | buzzer active, ring counter running
//   SNOOZE  | waiting for the snoozed eff time
module alarm_scheduler #(
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [5:0] alm_hour,
    input  logic [5:0] alm_min,
    input  logic       alarm_en,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    output logic [1:0] state,
    output logic       ringing,
    output logic       buzzer,
    output logic [1:0] snooze_count,
    output logic [5:0] eff_hour,
    output logic [5:0] eff_min
);

    localparam int CNT_W = (RING_TIMEOUT_SEC > 1) ? $clog2(RING_TIMEOUT_SEC) : 1;
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TIMEOUT_SEC - 1);
    localparam logic [1:0]       SNZ_MAX   = 2'(MAX_SNOOZE);
    localparam logic [6:0]       SNZ_ADD   = 7'(SNOOZE_MIN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_RINGING = 2'b10,
        S_SNOOZE  = 2'b11
    } state_t;

    state_t           r_state;
    logic             r_ringing;
    logic             r_buzzer;
    logic [1:0]       r_snz_cnt;
    logic [5:0]       r_eff_hour;
    logic [5:0]       r_eff_min;
    logic [CNT_W-1:0] r_ring_cnt;
    logic             r_stop_prev;
    logic             r_snz_prev;
    logic             r_match_prev;

    state_t           w_state_nxt;
    logic             w_buzzer_nxt;
    logic [1:0]       w_snz_cnt_nxt;
    logic [5:0]       w_eff_hour_nxt;
    logic [5:0]       w_eff_min_nxt;
    logic [CNT_W-1:0] w_ring_cnt_nxt;

    logic             w_match;
    logic             w_trigger;
    logic             w_stop_edge;
    logic             w_snz_edge;
    logic             w_timeout;
    logic [6:0]       w_min_sum;
    logic [6:0]       w_min_sum_m60;
    logic             w_min_wrap;
    logic [5:0]       w_snz_min;
    logic [5:0]       w_snz_hour;

    assign w_match     = (cur_hour == r_eff_hour) && (cur_min == r_eff_min) && (cur_sec == 6'd0);
    assign w_trigger   = w_match && !r_match_prev;
    assign w_stop_edge = btn_stop && !r_stop_prev;
    assign w_snz_edge  = btn_snooze && !r_snz_prev;
    assign w_timeout   = tick_1s && (r_ring_cnt == RING_LAST);

    // Snooze target: current time plus SNOOZE_MIN, minute carry into hour, hour wraps at 24.
    assign w_min_sum     = {1'b0, cur_min} + SNZ_ADD;
    assign w_min_sum_m60 = w_min_sum - 7'd60;
    assign w_min_wrap    = (w_min_sum >= 7'd60);
    assign w_snz_min     = w_min_wrap ? w_min_sum_m60[5:0] : w_min_sum[5:0];
    assign w_snz_hour    = !w_min_wrap ? cur_hour :
                           ((cur_hour >= 6'd23) ? 6'd0 : cur_hour + 6'd1);

    always_comb begin
        w_state_nxt    = r_state;
        w_buzzer_nxt   = r_buzzer;
        w_snz_cnt_nxt  = r_snz_cnt;
        w_eff_hour_nxt = r_eff_hour;
        w_eff_min_nxt  = r_eff_min;
        w_ring_cnt_nxt = r_ring_cnt;

        if (r_state == S_IDLE || r_state == S_ARMED) begin
            w_eff_hour_nxt = alm_hour;
            w_eff_min_nxt  = alm_min;
        end

        if (!alarm_en) begin
            w_state_nxt    = S_IDLE;
            w_buzzer_nxt   = 1'b0;
            w_snz_cnt_nxt  = 2'd0;
            w_ring_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_ARMED;
                S_ARMED: begin
                    if (w_trigger) begin
                        w_state_nxt    = S_RINGING;
                        w_buzzer_nxt   = 1'b1;
                        w_ring_cnt_nxt = '0;
                    end
                end
                S_RINGING: begin
                    // Stop beats snooze; a stop or timeout on a tick leaves the buzzer off.
                    if (w_stop_edge || w_timeout) begin
                        w_state_nxt   = S_ARMED;
                        w_snz_cnt_nxt = 2'd0;
                        w_buzzer_nxt  = 1'b0;
                    end else if (w_snz_edge && (r_snz_cnt < SNZ_MAX)) begin
                        w_state_nxt    = S_SNOOZE;
                        w_snz_cnt_nxt  = r_snz_cnt + 2'd1;
                        w_buzzer_nxt   = 1'b0;
                        w_eff_hour_nxt = w_snz_hour;
                        w_eff_min_nxt  = w_snz_min;
                    end else if (tick_1s) begin
                        w_ring_cnt_nxt = r_ring_cnt + CNT_W'(1);
                        w_buzzer_nxt   = !r_buzzer;
                    end
                end
                S_SNOOZE: begin
                    if (w_stop_edge) begin
                        w_state_nxt   = S_ARMED;
                        w_snz_cnt_nxt = 2'd0;
                    end else if (w_trigger) begin
                        w_state_nxt    = S_RINGING;
                        w_buzzer_nxt   = 1'b1;
                        w_ring_cnt_nxt = '0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ringing    <= 1'b0;
            r_buzzer     <= 1'b0;
            r_snz_cnt    <= 2'd0;
            r_eff_hour   <= 6'd0;
            r_eff_min    <= 6'd0;
            r_ring_cnt   <= '0;
            r_stop_prev  <= 1'b0;
            r_snz_prev   <= 1'b0;
            r_match_prev <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ringing    <= (w_state_nxt == S_RINGING);
            r_buzzer     <= w_buzzer_nxt;
            r_snz_cnt    <= w_snz_cnt_nxt;
            r_eff_hour   <= w_eff_hour_nxt;
            r_eff_min    <= w_eff_min_nxt;
            r_ring_cnt   <= w_ring_cnt_nxt;
            r_stop_prev  <= btn_stop;
            r_snz_prev   <= btn_snooze;
            r_match_prev <= w_match;
        end
    end

    assign state        = r_state;
    assign ringing      = r_ringing;
    assign buzzer       = r_buzzer;
    assign snooze_count = r_snz_cnt;
    assign eff_hour     = r_eff_hour;
    assign eff_min      = r_eff_min;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: vector table, hand-written corner sequences and a random phase,
// every cycle compared against a time-of-day reference model.
module tb_alarm_scheduler;

    localparam int SNOOZE_MIN       = 5;
    localparam int RING_TIMEOUT_SEC = 60;
    localparam int MAX_SNOOZE       = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1s;
    logic [5:0] cur_hour, cur_min, cur_sec;
    logic [5:0] alm_hour, alm_min;
    logic       alarm_en, btn_stop, btn_snooze;
    logic [1:0] state, snooze_count;
    logic       ringing, buzzer;
    logic [5:0] eff_hour, eff_min;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tod     = 0;

    // Reference model: eff kept as minutes of day, ring time as elapsed seconds.
    int m_state, m_eff, m_snz, m_elapsed;
    bit m_pstop, m_psnz, m_pmatch;

    typedef struct packed {
        logic       tick;
        logic       stop;
        logic       snz;
        logic       en;
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] e_state;
        logic       e_ring;
        logic       e_buz;
        logic [1:0] e_cnt;
        logic [5:0] e_eh;
        logic [5:0] e_em;
    } vec_t;

    vec_t tbl[13];

    always #5 clk = ~clk;

    alarm_scheduler #(
        .SNOOZE_MIN      (SNOOZE_MIN),
        .RING_TIMEOUT_SEC(RING_TIMEOUT_SEC),
        .MAX_SNOOZE      (MAX_SNOOZE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1s     (tick_1s),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .cur_sec     (cur_sec),
        .alm_hour    (alm_hour),
        .alm_min     (alm_min),
        .alarm_en    (alarm_en),
        .btn_stop    (btn_stop),
        .btn_snooze  (btn_snooze),
        .state       (state),
        .ringing     (ringing),
        .buzzer      (buzzer),
        .snooze_count(snooze_count),
        .eff_hour    (eff_hour),
        .eff_min     (eff_min)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {14'd0, state, ringing, buzzer, snooze_count, eff_hour, eff_min};
    endfunction

    function automatic logic [31:0] model_outs();
        logic ring;
        logic buz;
        ring = (m_state == 2);
        buz  = ring && ((m_elapsed % 2) == 0);
        return {14'd0, 2'(m_state), ring, buz, 2'(m_snz), 6'(m_eff / 60), 6'(m_eff % 60)};
    endfunction

    function automatic void model_reset();
        m_state   = 0;
        m_eff     = 0;
        m_snz     = 0;
        m_elapsed = 0;
        m_pstop   = 1'b0;
        m_psnz    = 1'b0;
        m_pmatch  = 1'b0;
    endfunction

    task automatic model_clock();
        int now_min;
        int eff_n;
        bit match, trig, stop_e, snz_e, timed_out;
        now_min   = int'(cur_hour) * 60 + int'(cur_min);
        match     = (now_min == m_eff) && (cur_sec == 6'd0);
        trig      = match && !m_pmatch;
        stop_e    = btn_stop && !m_pstop;
        snz_e     = btn_snooze && !m_psnz;
        timed_out = tick_1s && (m_elapsed == RING_TIMEOUT_SEC - 1);
        eff_n     = m_eff;
        if (m_state <= 1) eff_n = int'(alm_hour) * 60 + int'(alm_min);
        if (!alarm_en) begin
            m_state = 0; m_snz = 0; m_elapsed = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (trig) begin m_state = 2; m_elapsed = 0; end
        end else if (m_state == 2) begin
            if (stop_e || timed_out) begin
                m_state = 1; m_snz = 0;
            end else if (snz_e && m_snz < MAX_SNOOZE) begin
                m_state = 3; m_snz++;
                eff_n = (now_min + SNOOZE_MIN) % 1440;
            end else if (tick_1s) begin
                m_elapsed++;
            end
        end else begin
            if (stop_e) begin
                m_state = 1; m_snz = 0;
            end else if (trig) begin
                m_state = 2; m_elapsed = 0;
            end
        end
        m_eff    = eff_n;
        m_pstop  = btn_stop;
        m_psnz   = btn_snooze;
        m_pmatch = match;
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        cyc++;
        #1;
        check($sformatf("cycle%0d", cyc), dut_outs(), model_outs());
    endtask

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    task automatic set_tod(input int t);
        tod      = t;
        cur_hour = 6'(t / 3600);
        cur_min  = 6'((t / 60) % 60);
        cur_sec  = 6'(t % 60);
    endtask

    task automatic tick_to(input int t);
        set_tod(t);
        tick_1s = 1'b1;
        step();
        tick_1s = 1'b0;
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("async_rst", dut_outs(), 32'd0);
        model_reset();
        #2 rst = 1'b0;
    endtask

    function automatic vec_t mk(input int tk, input int st, input int sz, input int en,
                                input int h, input int m, input int s,
                                input int es, input int er, input int eb, input int ec,
                                input int eh, input int em);
        vec_t v;
        v.tick = 1'(tk);  v.stop = 1'(st);  v.snz = 1'(sz);  v.en = 1'(en);
        v.h = 6'(h);      v.m = 6'(m);      v.s = 6'(s);
        v.e_state = 2'(es); v.e_ring = 1'(er); v.e_buz = 1'(eb); v.e_cnt = 2'(ec);
        v.e_eh = 6'(eh);  v.e_em = 6'(em);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int now_m;

        //               tk st sz en  h  m  s | st ring buz cnt eh em
        tbl[0]  = mk(0, 0, 0, 1, 7, 29, 58,  1, 0, 0, 0, 7, 30);
        tbl[1]  = mk(1, 0, 0, 1, 7, 29, 59,  1, 0, 0, 0, 7, 30);
        tbl[2]  = mk(1, 0, 0, 1, 7, 30,  0,  2, 1, 1, 0, 7, 30);
        tbl[3]  = mk(0, 0, 0, 1, 7, 30,  0,  2, 1, 1, 0, 7, 30);
        tbl[4]  = mk(1, 0, 0, 1, 7, 30,  1,  2, 1, 0, 0, 7, 30);
        tbl[5]  = mk(1, 0, 0, 1, 7, 30,  2,  2, 1, 1, 0, 7, 30);
        tbl[6]  = mk(0, 0, 1, 1, 7, 30,  2,  3, 0, 0, 1, 7, 35);
        tbl[7]  = mk(0, 0, 0, 1, 7, 30,  2,  3, 0, 0, 1, 7, 35);
        tbl[8]  = mk(1, 0, 0, 1, 7, 34, 59,  3, 0, 0, 1, 7, 35);
        tbl[9]  = mk(1, 0, 0, 1, 7, 35,  0,  2, 1, 1, 1, 7, 35);
        tbl[10] = mk(0, 1, 1, 1, 7, 35,  0,  1, 0, 0, 0, 7, 35);
        tbl[11] = mk(0, 1, 1, 1, 7, 35,  0,  1, 0, 0, 0, 7, 30);
        tbl[12] = mk(1, 0, 0, 1, 7, 35,  1,  1, 0, 0, 0, 7, 30);

        rst = 1'b1;
        tick_1s = 1'b0; btn_stop = 1'b0; btn_snooze = 1'b0; alarm_en = 1'b0;
        alm_hour = 6'd7; alm_min = 6'd30;
        set_tod(hms(7, 29, 58));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_outs(), 32'd0);
        rst = 1'b0;

        // Basic ring, snooze, re-ring, simultaneous stop+snooze, no retrigger in same minute
        for (int i = 0; i < 13; i++) begin
            tick_1s    = tbl[i].tick;
            btn_stop   = tbl[i].stop;
            btn_snooze = tbl[i].snz;
            alarm_en   = tbl[i].en;
            set_tod(hms(int'(tbl[i].h), int'(tbl[i].m), int'(tbl[i].s)));
            step();
            check($sformatf("vec%0d", i), dut_outs(),
                  {14'd0, tbl[i].e_state, tbl[i].e_ring, tbl[i].e_buz, tbl[i].e_cnt,
                   tbl[i].e_eh, tbl[i].e_em});
        end
        tick_1s = 1'b0; btn_stop = 1'b0; btn_snooze = 1'b0;

        // Midnight wrap and snooze limit
        alm_hour = 6'd23; alm_min = 6'd58;
        tick_to(hms(23, 57, 59));
        tick_to(hms(23, 58, 0));
        check("wrap_ring", {30'd0, state}, 32'd2);
        now_m = 23 * 60 + 58;
        for (int k = 1; k <= MAX_SNOOZE; k++) begin
            int nxt;
            nxt = (now_m + SNOOZE_MIN) % 1440;
            btn_snooze = 1'b1;
            step();
            check("snz_state", {30'd0, state}, 32'd3);
            check("snz_cnt", {30'd0, snooze_count}, k);
            check("snz_eff", {20'd0, eff_hour, eff_min}, {20'd0, 6'(nxt / 60), 6'(nxt % 60)});
            if (k == 1) check("wrap_eff_0003", {20'd0, eff_hour, eff_min}, {20'd0, 6'd0, 6'd3});
            btn_snooze = 1'b0;
            step();
            tick_to((nxt * 60 - 1 + 86400) % 86400);
            tick_to(nxt * 60);
            check("snz_ring", {30'd0, state}, 32'd2);
            now_m = nxt;
        end
        btn_snooze = 1'b1;
        step();
        check("snz_ignored", {28'd0, state, snooze_count}, {28'd0, 2'b10, 2'd3});
        btn_snooze = 1'b0;
        step();

        // Ring timeout with buzzer pattern
        for (int t = 1; t <= RING_TIMEOUT_SEC; t++) begin
            tick_to((tod + 1) % 86400);
            if (t < RING_TIMEOUT_SEC)
                check($sformatf("ring_t%0d", t), {29'd0, state, buzzer},
                      {29'd0, 2'b10, ((t % 2) == 0) ? 1'b1 : 1'b0});
            else
                check("timeout", {27'd0, state, buzzer, snooze_count}, {27'd0, 2'b01, 1'b0, 2'd0});
        end
        step();
        check("eff_revert", {20'd0, eff_hour, eff_min}, {20'd0, 6'd23, 6'd58});

        // Asynchronous reset mid-ring, then alarm_en drop during snooze
        alm_hour = 6'd7; alm_min = 6'd30;
        tick_to(hms(7, 29, 59));
        tick_to(hms(7, 30, 0));
        tick_to(hms(7, 30, 1));
        check("pre_rst_ring", {31'd0, ringing}, 32'd1);
        async_reset();
        step();
        check("post_rst_armed", {30'd0, state}, 32'd1);
        tick_to(hms(7, 30, 2));
        check("no_resume", {30'd0, state}, 32'd1);
        tick_to(hms(7, 29, 59));
        tick_to(hms(7, 30, 0));
        check("ring_again", {30'd0, state}, 32'd2);
        btn_snooze = 1'b1;
        step();
        btn_snooze = 1'b0;
        step();
        check("in_snooze", {30'd0, state}, 32'd3);
        alarm_en = 1'b0;
        step();
        check("en_off", {26'd0, state, ringing, buzzer, snooze_count}, 32'd0);
        alarm_en = 1'b1;
        step();
        check("rearm", {30'd0, state}, 32'd1);

        // Random phase against the model
        alm_hour = 6'($urandom_range(0, 23));
        alm_min  = 6'($urandom_range(0, 59));
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            tick_1s = 1'b0;
            if (r < 10)
                set_tod(((m_eff * 60 - int'($urandom_range(1, 3))) % 86400 + 86400) % 86400);
            else if (r < 400) begin
                set_tod((tod + 1) % 86400);
                tick_1s = 1'b1;
            end
            if ($urandom_range(0, 99) < 2) btn_stop = ~btn_stop;
            if ($urandom_range(0, 99) < 3) btn_snooze = ~btn_snooze;
            alarm_en = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
